// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One radix-2 step per cycle over 32 cycles: shift-add for multiply and
// restoring shift-subtract for divide. Signed operations run on operand
// magnitudes, and the result signs are fixed on the final step.
module mult_div_unit (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        res_neg_q, res_neg_d;   // negate product / quotient
   logic        rem_neg_q, rem_neg_d;   // negate remainder
   logic [63:0] p_q, p_d;               // mul: {acc, multiplier}; div: {rem, dividend/quotient}
   logic [31:0] m_q, m_d;               // multiplicand or divisor magnitude
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        signed_op, op_div, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] add_sum;
   logic [32:0] rem_sh;
   logic [33:0] sub_diff;
   logic [63:0] step;
   logic [63:0] prod_fix;

   // Operand magnitudes and signs at the accept edge
   always_comb begin
      signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
      op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
      a_neg     = signed_op & a_i[31];
      b_neg     = signed_op & b_i[31];
      a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
      b_mag     = b_neg ? (~b_i + 32'd1) : b_i;
   end

   // One radix-2 iteration of the active operation
   always_comb begin
      add_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
      rem_sh   = {p_q[63:32], p_q[31]};
      sub_diff = {1'b0, rem_sh} - {2'b00, m_q};
      if (is_div_q) begin
         // Restoring divide: keep the shifted remainder when the subtract goes negative
         step = sub_diff[33] ? {rem_sh[31:0], p_q[30:0], 1'b0}
                             : {sub_diff[31:0], p_q[30:0], 1'b1};
      end else begin
         step = {add_sum, p_q[31:1]};
      end
      prod_fix = res_neg_q ? (~step + 64'd1) : step;
   end

   // Next-state, datapath and output control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      p_d       = p_q;
      m_d       = m_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               case (op_i)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d   = BUSY;
                     cnt_d     = 5'd31;
                     is_div_d  = op_div;
                     m_d       = op_div ? b_mag : a_mag;
                     p_d       = {32'd0, op_div ? a_mag : b_mag};
                     // Divide by zero keeps the all-ones quotient unsigned
                     res_neg_d = (a_neg ^ b_neg) && !(op_div && (b_i == 32'd0));
                     rem_neg_d = a_neg;
                  end
                  OP_MTHI: hi_d = a_i;
                  OP_MTLO: lo_d = a_i;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            p_d   = step;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
               done_d  = 1'b1;
               if (is_div_q) begin
                  lo_d = res_neg_q ? (~step[31:0] + 32'd1) : step[31:0];
                  hi_d = rem_neg_q ? (~step[63:32] + 32'd1) : step[63:32];
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Datapath and result registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         p_q       <= 64'd0;
         m_q       <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         p_q       <= p_d;
         m_q       <= m_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy_o = (state_q == BUSY);
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
